// File: rtl/game_flow_ctrl_if.sv
// Bundle of the game sequencer's event inputs and HUD/motion outputs.
// The slave side is the sequencer; the master side is whoever drives events.
interface game_flow_ctrl_if;
    logic        frame_tick;
    logic        start_btn;
    logic        pause_btn;
    logic        collision;
    logic [1:0]  state;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        play_en;
    logic        invuln;
    logic        blink;
    logic        game_over;

    modport master (
        output frame_tick, start_btn, pause_btn, collision,
        input  state, lives, score, play_en, invuln, blink, game_over
    );

    modport slave (
        input  frame_tick, start_btn, pause_btn, collision,
        output state, lives, score, play_en, invuln, blink, game_over
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer for the JOJO runner: game state, lives, score,
// post-hit invulnerability with sprite blink, and pause. Motion elsewhere is
// gated by play_en; HUD and blink go to the renderer.
module game_flow_ctrl #(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned SCORE_DIV     = 6,
    parameter int unsigned BLINK_FRAMES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    game_flow_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [7:0] TIMER_LOAD = 8'(INVULN_FRAMES);
    localparam logic [5:0] DIV_LAST   = 6'(SCORE_DIV - 1);
    localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

    state_t      state_q;
    logic [2:0]  lives_q;
    logic [15:0] score_q;
    logic [5:0]  div_q;
    logic [7:0]  timer_q;
    logic [5:0]  blink_cnt_q;
    logic        blink_q;
    logic        paused_q;
    logic        start_q;
    logic        pause_q;

    logic start_rise;
    logic pause_rise;

    assign start_rise = bus.start_btn & ~start_q;
    assign pause_rise = bus.pause_btn & ~pause_q;

    // Sequencer: edge-detect registers, game state, scoring, invulnerability and pause.
    always_ff @(posedge clk) begin
        // Edge-detect registers track the buttons every cycle, reset included,
        // so a button held through reset is not seen as a press.
        start_q <= bus.start_btn;
        pause_q <= bus.pause_btn;
        if (rst) begin
            state_q     <= IDLE;
            lives_q     <= LIVES_LOAD;
            score_q     <= '0;
            div_q       <= '0;
            timer_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        state_q     <= PLAY;
                        lives_q     <= LIVES_LOAD;
                        score_q     <= '0;
                        div_q       <= '0;
                        timer_q     <= '0;
                        blink_cnt_q <= '0;
                        blink_q     <= 1'b0;
                        paused_q    <= 1'b0;
                    end
                end
                PLAY, HIT: begin
                    // A pause press takes the whole cycle: any collision or
                    // tick arriving with it is dropped.
                    if (pause_rise) begin
                        paused_q <= ~paused_q;
                    end else if (!paused_q) begin
                        if (bus.frame_tick) begin
                            if (div_q == DIV_LAST) begin
                                div_q <= '0;
                                if (score_q != '1) begin
                                    score_q <= score_q + 16'd1;
                                end
                            end else begin
                                div_q <= div_q + 6'd1;
                            end
                        end
                        if (state_q == PLAY) begin
                            if (bus.collision) begin
                                if (lives_q > 3'd1) begin
                                    state_q     <= HIT;
                                    lives_q     <= lives_q - 3'd1;
                                    timer_q     <= TIMER_LOAD;
                                    blink_cnt_q <= '0;
                                    blink_q     <= 1'b1;
                                end else begin
                                    state_q  <= OVER;
                                    lives_q  <= '0;
                                    paused_q <= 1'b0;
                                end
                            end
                        end else if (bus.frame_tick) begin
                            if (timer_q == 8'd1) begin
                                state_q     <= PLAY;
                                timer_q     <= '0;
                                blink_cnt_q <= '0;
                                blink_q     <= 1'b0;
                            end else begin
                                timer_q <= timer_q - 8'd1;
                                if (blink_cnt_q == BLINK_LAST) begin
                                    blink_cnt_q <= '0;
                                    blink_q     <= ~blink_q;
                                end else begin
                                    blink_cnt_q <= blink_cnt_q + 6'd1;
                                end
                            end
                        end
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        state_q  <= IDLE;
                        lives_q  <= LIVES_LOAD;
                        score_q  <= '0;
                        paused_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.lives     = lives_q;
    assign bus.score     = score_q;
    assign bus.play_en   = ((state_q == PLAY) || (state_q == HIT)) && !paused_q;
    assign bus.invuln    = (state_q == HIT);
    assign bus.blink     = blink_q;
    assign bus.game_over = (state_q == OVER);
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: a stimulus table plus hand-written sequences for
// hits, invulnerability, pause, game over and reset; a second instance with a
// one-frame score divider covers score saturation.
module tb_game_flow_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    game_flow_ctrl_if bus ();
    game_flow_ctrl_if bus2 ();

    game_flow_ctrl #(
        .LIVES_INIT    (3),
        .INVULN_FRAMES (60),
        .SCORE_DIV     (6),
        .BLINK_FRAMES  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    game_flow_ctrl #(
        .LIVES_INIT    (3),
        .INVULN_FRAMES (60),
        .SCORE_DIV     (1),
        .BLINK_FRAMES  (4)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct packed {
        logic [1:0]  state;
        logic [2:0]  lives;
        logic [15:0] score;
        logic        play_en;
        logic        invuln;
        logic        blink;
        logic        game_over;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    typedef struct {
        logic ft;
        logic st;
        logic pb;
        logic col;
        out_t exp;
    } vec_t;

    sb_t         sbq[$];
    int unsigned n_cmp  = 0;
    int unsigned n_err  = 0;
    int unsigned nticks = 0;

    function automatic out_t mk(input logic [1:0] s, input logic [2:0] l, input logic [15:0] sc,
                                input logic pe, input logic inv, input logic bl, input logic go);
        out_t o;
        o.state     = s;
        o.lives     = l;
        o.score     = sc;
        o.play_en   = pe;
        o.invuln    = inv;
        o.blink     = bl;
        o.game_over = go;
        return o;
    endfunction

    function automatic vec_t mkv(input logic ft, input logic st, input logic pb, input logic col,
                                 input out_t e);
        vec_t v;
        v.ft  = ft;
        v.st  = st;
        v.pb  = pb;
        v.col = col;
        v.exp = e;
        return v;
    endfunction

    function automatic out_t snap1();
        return mk(bus.state, bus.lives, bus.score, bus.play_en, bus.invuln, bus.blink, bus.game_over);
    endfunction

    function automatic out_t snap2();
        return mk(bus2.state, bus2.lives, bus2.score, bus2.play_en, bus2.invuln, bus2.blink,
                  bus2.game_over);
    endfunction

    // Expected score from scoring ticks seen since the last game start.
    function automatic logic [15:0] sc();
        return 16'(nticks / 6);
    endfunction

    // Expected blink after k invulnerability ticks: starts high, flips every 4 ticks.
    function automatic logic bexp(input int unsigned k);
        return ((k / 4) % 2) == 0;
    endfunction

    task automatic pop_cmp(input out_t act);
        sb_t it;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: got output with no expectation queued, required a queued entry");
        end else begin
            it = sbq.pop_front();
            if (act !== it.exp) begin
                n_err++;
                $display("FAIL %s: got state=%0d lives=%0d score=%0d play_en=%0b invuln=%0b blink=%0b game_over=%0b, required state=%0d lives=%0d score=%0d play_en=%0b invuln=%0b blink=%0b game_over=%0b",
                         it.name, act.state, act.lives, act.score, act.play_en, act.invuln,
                         act.blink, act.game_over, it.exp.state, it.exp.lives, it.exp.score,
                         it.exp.play_en, it.exp.invuln, it.exp.blink, it.exp.game_over);
            end
        end
    endtask

    task automatic push_exp(input string name, input out_t e);
        sb_t it;
        it.name = name;
        it.exp  = e;
        sbq.push_back(it);
    endtask

    task automatic step(input string name, input logic ft, input logic st, input logic pb,
                        input logic col, input out_t e);
        bus.frame_tick = ft;
        bus.start_btn  = st;
        bus.pause_btn  = pb;
        bus.collision  = col;
        push_exp(name, e);
        @(posedge clk);
        #1;
        pop_cmp(snap1());
    endtask

    task automatic sat_step(input string name, input out_t e);
        push_exp(name, e);
        @(posedge clk);
        #1;
        pop_cmp(snap2());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion within time limit, required self-termination");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[18];

        rst             = 1'b1;
        bus.frame_tick  = 1'b0;
        bus.start_btn   = 1'b1;
        bus.pause_btn   = 1'b0;
        bus.collision   = 1'b0;
        bus2.frame_tick = 1'b0;
        bus2.start_btn  = 1'b0;
        bus2.pause_btn  = 1'b0;
        bus2.collision  = 1'b0;

        @(posedge clk);
        #1;
        step("reset", 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;

        // Start held through reset, pause in IDLE, start edge, pause/unpause, scoring.
        tbl[0]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[1]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[2]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[3]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[4]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[5]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[7]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[8]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, mk(2'd1, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[9]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[10] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[11] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[12] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[13] = mkv(1'b0, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[14] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[15] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[16] = mkv(1'b0, 1'b1, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[17] = mkv(1'b0, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), tbl[i].ft, tbl[i].st, tbl[i].pb, tbl[i].col, tbl[i].exp);
        end
        nticks = 6;

        // 18 more frame ticks: three more points.
        for (int i = 1; i <= 18; i++) begin
            nticks++;
            step("score_tick", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, sc(), 1'b1, 1'b0, 1'b0, 1'b0));
            step("score_gap", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd3, sc(), 1'b1, 1'b0, 1'b0, 1'b0));
        end

        // Collision held for 100 clocks: one hit only.
        for (int i = 0; i < 100; i++) begin
            step("hit_hold", 1'b0, 1'b0, 1'b0, 1'b1, mk(2'd2, 3'd2, sc(), 1'b1, 1'b1, 1'b1, 1'b0));
        end
        // 60 invulnerability ticks; the last one carries a collision that must be ignored.
        for (int k = 1; k <= 60; k++) begin
            nticks++;
            if (k < 60) begin
                step("invuln_tick", 1'b1, 1'b0, 1'b0, 1'b0,
                     mk(2'd2, 3'd2, sc(), 1'b1, 1'b1, bexp(k), 1'b0));
            end else begin
                step("invuln_end", 1'b1, 1'b0, 1'b0, 1'b1,
                     mk(2'd1, 3'd2, sc(), 1'b1, 1'b0, 1'b0, 1'b0));
            end
        end
        step("after_invuln", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd2, sc(), 1'b1, 1'b0, 1'b0, 1'b0));

        // Second hit, pause at timer=30, frozen ticks and collision, then resume.
        step("hit2", 1'b0, 1'b0, 1'b0, 1'b1, mk(2'd2, 3'd1, sc(), 1'b1, 1'b1, 1'b1, 1'b0));
        for (int k = 1; k <= 30; k++) begin
            nticks++;
            step("hit2_tick", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'd2, 3'd1, sc(), 1'b1, 1'b1, bexp(k), 1'b0));
        end
        step("pause_in_hit", 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd2, 3'd1, sc(), 1'b0, 1'b1, bexp(30), 1'b0));
        for (int j = 0; j < 20; j++) begin
            step("paused_tick", 1'b1, 1'b0, 1'b0, (j == 10),
                 mk(2'd2, 3'd1, sc(), 1'b0, 1'b1, bexp(30), 1'b0));
        end
        step("unpause", 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd2, 3'd1, sc(), 1'b1, 1'b1, bexp(30), 1'b0));
        for (int m = 1; m <= 30; m++) begin
            nticks++;
            if (m < 30) begin
                step("resume_tick", 1'b1, 1'b0, 1'b0, 1'b0,
                     mk(2'd2, 3'd1, sc(), 1'b1, 1'b1, bexp(30 + m), 1'b0));
            end else begin
                step("resume_end", 1'b1, 1'b0, 1'b0, 1'b0,
                     mk(2'd1, 3'd1, sc(), 1'b1, 1'b0, 1'b0, 1'b0));
            end
        end

        // Pause press and collision together: pause wins.
        step("pause_vs_hit", 1'b0, 1'b0, 1'b1, 1'b1, mk(2'd1, 3'd1, sc(), 1'b0, 1'b0, 1'b0, 1'b0));
        step("paused_idle", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd1, sc(), 1'b0, 1'b0, 1'b0, 1'b0));
        step("unpause2", 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd1, 3'd1, sc(), 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++) begin
            if ((nticks % 6) != 5) begin
                nticks++;
                step("pre_tick", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'd1, 3'd1, sc(), 1'b1, 1'b0, 1'b0, 1'b0));
            end
        end
        // Fatal collision on a scoring tick: point counted, game over.
        nticks++;
        step("hit_and_tick", 1'b1, 1'b0, 1'b0, 1'b1, mk(2'd3, 3'd0, sc(), 1'b0, 1'b0, 1'b0, 1'b1));
        step("over_hold", 1'b1, 1'b0, 1'b1, 1'b1, mk(2'd3, 3'd0, sc(), 1'b0, 1'b0, 1'b0, 1'b1));
        step("over_hold2", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'd3, 3'd0, sc(), 1'b0, 1'b0, 1'b0, 1'b1));
        nticks = 0;
        step("over_start", 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("idle_after", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset while in HIT, with start held across it.
        step("restart", 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("hit3", 1'b0, 1'b0, 1'b0, 1'b1, mk(2'd2, 3'd2, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0));
        rst = 1'b1;
        step("rst_in_hit", 1'b0, 1'b1, 1'b0, 1'b1, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        step("held_start", 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("release", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'd0, 3'd3, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("start_again", 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // Saturation on the one-frame-per-point instance.
        bus2.start_btn = 1'b1;
        sat_step("sat_start", mk(2'd1, 3'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        bus2.start_btn  = 1'b0;
        bus2.frame_tick = 1'b1;
        repeat (65533) @(posedge clk);
        sat_step("sat_fffe", mk(2'd1, 3'd3, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0));
        sat_step("sat_ffff", mk(2'd1, 3'd3, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++) begin
            sat_step("sat_hold", mk(2'd1, 3'd3, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        bus2.frame_tick = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the JOJO runner.
- Consumes the registered collision flag from the collision detector, the per-frame tick from the VGA timing block, and the debounced start/pause buttons.
- Owns game state, lives, score, post-hit invulnerability and pause.
- Gates sprite and mask motion through play_en; drives HUD and blink outputs to the renderer.

Parameters:
LIVES_INIT, 3, lives loaded at game start; legal range 1..7.
INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit; legal range 1..255.
SCORE_DIV, 6, frames per score point; legal range 1..63.
BLINK_FRAMES, 4, frames per blink half-period during invulnerability; legal range 1..63.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
frame_tick  in  1  one-cycle pulse, once per video frame.
start_btn  in  1  debounced level; acted on at its rising edge.
pause_btn  in  1  debounced level; acted on at its rising edge.
collision  in  1  registered collision level from the detector.
state  out  2  current state: IDLE=0, PLAY=1, HIT=2, OVER=3.
lives  out  3  remaining lives.
score  out  16  current score; saturates at 16'hFFFF.
play_en  out  1  high in PLAY/HIT when not paused; enables motion.
invuln  out  1  high in HIT.
blink  out  1  sprite hide strobe during invulnerability.
game_over  out  1  high in OVER.

Behaviour:
- Reset: all registers update only on a clk edge with rst=1.
  - state=IDLE, lives=LIVES_INIT, score=0, play_en=0, invuln=0, blink=0, game_over=0.
  - Internal frame divider, invulnerability timer, blink counter and paused flag all 0.
  - start/pause edge-detect registers load the current button levels, so a button already held through reset is not an edge.
  - rst mid-game behaves identically, from any state.
- Edge detect: start_rise = start_btn & ~start_q; pause_rise = pause_btn & ~pause_q. The _q registers are updated every cycle.
- IDLE:
  - play_en=0.
  - start_rise: next cycle state=PLAY, lives=LIVES_INIT, score=0, divider=0.
- PLAY (not paused):
  - On frame_tick, the divider increments. When it reaches SCORE_DIV-1, it wraps to 0 and score increments, saturating at 16'hFFFF.
  - collision=1 with lives>1: next cycle state=HIT, lives-1, timer=INVULN_FRAMES, blink counter=0, blink=1.
  - collision=1 with lives==1: next cycle state=OVER, lives=0.
  - Hit response latency is exactly 1 clk.
- HIT (not paused):
  - Scoring continues as in PLAY; collision is ignored.
  - On each frame_tick, timer decrements.
  - On the tick where timer goes 1->0, state=PLAY next cycle and blink=0.
  - The blink counter counts frame_ticks and toggles blink every BLINK_FRAMES ticks.
- OVER:
  - play_en=0, game_over=1; score and lives are held for display.
  - start_rise: next cycle state=IDLE, with score=0 and lives=LIVES_INIT.
- Pause:
  - pause_rise in PLAY/HIT toggles paused.
  - While paused: play_en=0; frame_tick has no effect (divider, score, timer and blink all frozen); collision is ignored.
  - pause_rise in IDLE/OVER is ignored.
  - paused is cleared on entry to IDLE or OVER.
- Simultaneous events:
  - pause_rise and collision in the same cycle in PLAY: pause wins and the collision is dropped.
  - collision and frame_tick in the same cycle in PLAY: the score update and the hit both apply.
  - The final tick of the HIT timer and a collision in the same cycle: collision is ignored (still HIT that cycle).
  - start_rise in PLAY/HIT is ignored.
- Outputs are registered, or decoded directly from registered state; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then start pulse: state 0->1 one clk after the rising edge; lives=3, score=0, play_en=1. Holding start produces no further effect.
- PLAY, 18 frame_ticks, SCORE_DIV=6: score=3. Preload score 16'hFFFF and add 6 ticks: score stays 16'hFFFF.
- PLAY, lives=3, collision held 1 for 100 clks:
  - state=HIT next clk, lives=2, invuln=1.
  - lives stays 2 for the whole hold.
  - After 60 frame_ticks, state=PLAY and blink=0.
  - blink toggles every 4 ticks during HIT.
- lives=1, collision pulse: state=OVER next clk, lives=0, game_over=1, play_en=0. Then start: state=IDLE, score=0, lives=3.
- Pause in HIT with timer=30:
  - 20 frame_ticks plus a collision pulse: timer=30, score and lives unchanged, play_en=0.
  - Unpause, then 30 ticks: state=PLAY.
- Same-cycle pause_rise and collision in PLAY: paused=1 and lives unchanged. rst asserted in HIT: next clk state=IDLE, with all reset values present.
